// File: rtl/mips_instr_encoder_if.sv
// Descriptor stream between an instruction source and the MIPS encoder.
//   in_valid/in_ready : valid/ready handshake
//   in_op             : mnemonic code (0 ADD .. 9 J, 10-15 illegal)
//   in_rs/rt/rd       : register fields
//   in_imm            : 16-bit immediate / branch offset
//   in_target         : 26-bit jump target
//   in_last           : final descriptor of a load session
// master = descriptor producer, slave = encoder.
interface mips_instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        in_last;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target, in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target, in_last,
    output in_ready
  );
endinterface

// File: rtl/mips_instr_encoder.sv
// MIPS instruction encoder and loader. Accepts mnemonic descriptors over a
// valid/ready stream, packs each into a 32-bit MIPS word and writes the words
// sequentially into instruction memory starting at BASE_ADDR.
//   clk, rst     : clock, synchronous active-high reset
//   start        : one-cycle pulse, (re)starts a load session
//   dif          : descriptor stream (slave side)
//   wr_en/addr/data : instruction-memory write port (one strobe per word)
//   count        : words written this session
//   busy / done  : session loading / session finished
//   full         : session ended because DEPTH words were written
//   err          : sticky, an illegal opcode was seen this session
module mips_instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  mips_instr_encoder_if.slave dif,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [31:0]         wr_data,
  output logic [ADDR_W:0]     count,
  output logic                busy,
  output logic                done,
  output logic                full,
  output logic                err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

  // Opcodes 10..15 carry no encoding.
  function automatic logic op_legal(input logic [3:0] op);
    return (op <= 4'd9);
  endfunction

  // Pack a descriptor into the word layout the control decoder consumes.
  function automatic logic [31:0] encode(
    input logic [3:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [31:0] word_v;
    case (op)
      4'd0:    word_v = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
      4'd1:    word_v = {6'b000000, rs, rt, rd, 5'b00000, 6'b100010};
      4'd2:    word_v = {6'b000000, rs, rt, rd, 5'b00000, 6'b100100};
      4'd3:    word_v = {6'b000000, rs, rt, rd, 5'b00000, 6'b100101};
      4'd4:    word_v = {6'b000000, rs, rt, rd, 5'b00000, 6'b101010};
      4'd5:    word_v = {6'b100011, rs, rt, imm};
      4'd6:    word_v = {6'b101011, rs, rt, imm};
      4'd7:    word_v = {6'b000100, rs, rt, imm};
      4'd8:    word_v = {6'b001000, rs, rt, imm};
      4'd9:    word_v = {6'b000010, target};
      default: word_v = 32'h0000_0000;
    endcase
    return word_v;
  endfunction

  state_t              state_r;
  logic [ADDR_W:0]     count_r;
  logic                wr_en_r;
  logic [ADDR_W-1:0]   wr_addr_r;
  logic [31:0]         wr_data_r;
  logic                busy_r;
  logic                done_r;
  logic                full_r;
  logic                err_r;

  logic                ready_s;
  logic                fire_s;
  logic                legal_s;
  logic                hit_depth_s;
  logic [ADDR_W:0]     next_count_s;
  logic [ADDR_W-1:0]   addr_s;

  // Descriptors in the start cycle are refused so a restart never mixes sessions.
  assign ready_s      = (state_r == ST_LOAD) && (count_r < DEPTH_C) && !start;
  assign fire_s       = dif.in_valid && ready_s;
  assign legal_s      = op_legal(dif.in_op);
  assign next_count_s = count_r + (ADDR_W+1)'(1);
  assign hit_depth_s  = legal_s && (next_count_s == DEPTH_C);
  // count never exceeds DEPTH <= 2^ADDR_W while writing, so the low bits suffice;
  // the add wraps naturally past the top of memory.
  assign addr_s       = BASE_C + count_r[ADDR_W-1:0];
  assign dif.in_ready = ready_s;

  // Session FSM, write port and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      count_r   <= '0;
      wr_en_r   <= 1'b0;
      wr_addr_r <= '0;
      wr_data_r <= 32'h0000_0000;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      full_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      wr_en_r <= 1'b0;
      if (start) begin
        state_r <= ST_LOAD;
        count_r <= '0;
        full_r  <= 1'b0;
        err_r   <= 1'b0;
        busy_r  <= 1'b1;
        done_r  <= 1'b0;
      end else if (fire_s) begin
        if (legal_s) begin
          wr_en_r   <= 1'b1;
          wr_addr_r <= addr_s;
          wr_data_r <= encode(dif.in_op, dif.in_rs, dif.in_rt, dif.in_rd,
                              dif.in_imm, dif.in_target);
          count_r   <= next_count_s;
        end else begin
          // Illegal descriptor is consumed without a write.
          err_r <= 1'b1;
        end
        if (hit_depth_s) begin
          full_r <= 1'b1;
        end else begin
          full_r <= full_r;
        end
        if (hit_depth_s || dif.in_last) begin
          state_r <= ST_DONE;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
        end else begin
          state_r <= state_r;
        end
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign wr_en   = wr_en_r;
  assign wr_addr = wr_addr_r;
  assign wr_data = wr_data_r;
  assign count   = count_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign full    = full_r;
  assign err     = err_r;

endmodule

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
Instruction encoder and loader: the encoding side of the control path. It accepts mnemonic-level instruction descriptors over a valid/ready stream and packs them into 32-bit MIPS words (opcode/funct placed exactly as the control decoder consumes them). It writes the words sequentially into instruction memory through a write port. It is used at boot, or by the testbench, to fill program memory before the single-cycle core is released from reset.

Parameters:
ADDR_W, 8, instruction-memory word-address width
DEPTH, 256, maximum words loaded per session (1..2^ADDR_W)
BASE_ADDR, 0, first word address written after start

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins a load session
in_valid  in  1  descriptor valid
in_ready  out  1  encoder can accept a descriptor this cycle
in_op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LW, 6 SW, 7 BEQ, 8 ADDI, 9 J, 10-15 illegal
in_rs  in  5  source / base register
in_rt  in  5  second source or I-type destination
in_rd  in  5  R-type destination
in_imm  in  16  immediate / offset (raw bits)
in_target  in  26  J-type target field
in_last  in  1  marks final descriptor of session
wr_en  out  1  instruction-memory write strobe
wr_addr  out  ADDR_W  word address
wr_data  out  32  encoded instruction
count  out  ADDR_W+1  words written this session
busy  out  1  state == LOAD
done  out  1  state == DONE
full  out  1  session ended because count reached DEPTH
err  out  1  sticky: an illegal in_op was seen this session

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE. wr_en, wr_addr, wr_data, count, full, err, done and busy are all 0. Reset mid-session aborts the session. No write occurs on the cycle after the reset edge.
- FSM IDLE -> LOAD on start. LOAD -> DONE after the write of an in_last descriptor, or when count reaches DEPTH. DONE -> LOAD on start. DONE otherwise holds.
- start, in any state: clears count, full and err, and the address pointer returns to BASE_ADDR. In LOAD this restarts the session. Any descriptor presented in the start cycle is ignored (in_ready=0 that cycle).
- in_ready = (state==LOAD) & (count<DEPTH) & !start. Handshake fires when in_valid & in_ready. in_valid with in_ready=0 has no effect. Upstream holds its fields until accepted.
- Latency 1: a descriptor accepted at edge N produces wr_en=1 with wr_addr/wr_data valid for the cycle after N. Back-to-back accepts give back-to-back writes. wr_en is a single-cycle strobe per word. wr_addr and wr_data hold their last values when wr_en=0.
- Encoding:
  - R-type (ADD/SUB/AND/OR/SLT): {6'b000000, rs, rt, rd, 5'b00000, funct}, with funct 100000/100010/100100/100101/101010.
  - LW: {100011, rs, rt, imm}.
  - SW: {101011, rs, rt, imm}.
  - BEQ: {000100, rs, rt, imm}.
  - ADDI: {001000, rs, rt, imm}.
  - J: {000010, target}.
  - Unused fields are ignored.
- Illegal in_op (10-15): the descriptor is accepted (consumed) but not written. count is not advanced, err sets and stays set until start or rst. If it carries in_last, the FSM still goes to DONE.
- Addressing: wr_addr = (BASE_ADDR + count_before_write) mod 2^ADDR_W, so it wraps past the top of memory. count increments with each write.
- Full: once count==DEPTH, full=1 and the FSM enters DONE on that same edge, whether or not in_last was set. If in_last coincides with the DEPTH-th write, both conditions hold and full=1.

Test Plan:
- rst, start, then ADD rs=1 rt=2 rd=3 in_last=0 -> next cycle wr_en=1, wr_addr=0x00, wr_data=0x00221820; count=1; busy=1.
- LW rs=9 rt=8 imm=4, then BEQ rs=1 rt=2 imm=0xFFFF (in_last=1), back-to-back -> writes 0x8D280004 @0 and 0x1022FFFF @1 on consecutive cycles; done=1, count=2, full=0.
- J target=0x0000010 then in_op=12 with in_last=1 -> one write 0x08000010; err=1 stays set; count=1; done=1.
- DEPTH=4, BASE_ADDR=254, five SW descriptors with in_valid held high -> writes at 254, 255, 0, 1; in_ready drops after the 4th accept; full=1, done=1; the 5th is never accepted.
- rst asserted in the cycle after an accept -> no write strobe appears; all outputs read 0 on the next cycle.
- start pulsed during LOAD with in_valid=1 after two writes -> that descriptor is not accepted, count=0, err=0; the next accepted word is written at BASE_ADDR.
